mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Two-port arbiter sharing one 64-bit data + 8-bit tag memory between requesters.
//  Port 0 is the CPU bus adapter; port 1 is the I/O channel.
//  Round-robin with bounded lock for read-modify-write sequences. Fixed-latency read path.
//  Sits between the requesters and the main memory array, under the sectest/initest benches.
// PARAMETERS
//  AW        20  word address width
//  DW        64  data width
//  TW        8   tag width
//  RD_LAT    2   memory read latency in cycles, >=1 (mem_en cycle -> rdata valid cycle)
//  LOCK_MAX  4   max consecutive locked grants to one port while the other port waits, >=1
// PORTS
//  clk        in   1      clock, all state on posedge
//  reset      in   1      synchronous, active-high
//  req_valid  in   2      per-port request; payload held stable until req_ack
//  req_we     in   2      1=write, 0=read
//  req_lock   in   2      keep grant for next request of same port
//  req_addr   in   2*AW   port i at [i*AW +: AW]
//  req_wdata  in   2*DW   write data per port
//  req_wtag   in   2*TW   write tag per port
//  req_ack    out  2      one-cycle accept pulse
//  rsp_valid  out  2      one-cycle read response pulse
//  rsp_data   out  DW     read data, held until next response
//  rsp_tag    out  TW     read tag, held until next response
//  busy       out  1      state != IDLE
//  mem_en     out  1      memory access strobe, one cycle
//  mem_we     out  1      write enable, qualified by mem_en
//  mem_addr   out  AW     registered address
//  mem_wdata  out  DW     registered write data
//  mem_wtag   out  TW     registered write tag
//  mem_rdata  in   DW     read data, valid RD_LAT cycles after mem_en
//  mem_rtag   in   TW     read tag, same timing as mem_rdata
// BEHAVIOUR
//  Reset values:
//   - outputs: all 0; state=IDLE
//   - internal: last=1 (port 0 wins first tie), lock_cnt=0, wait counter=0
//  FSM:
//   - IDLE: grant g on edge when any req_valid. Registers payload[g] into mem_*.
//     Next cycle mem_en=1 and req_ack[g]=1 together -> ISSUE.
//   - ISSUE, write: -> IDLE. Earliest next mem_en is 2 cycles later.
//   - ISSUE, read: -> WAIT, counter=RD_LAT-1. RD_LAT=1 goes straight to RESP capture.
//   - WAIT: decrement each cycle. At 0, capture mem_rdata/mem_rtag on the edge -> IDLE.
//     rsp_valid[g] pulses the next cycle with rsp_data/rsp_tag.
//   - Read timing: rsp_valid at ISSUE+RD_LAT+1; next mem_en no earlier than ISSUE+RD_LAT+2.
//   - Arbitration in the rsp_valid cycle is allowed; rsp and new ack may coincide.
//  Arbitration (IDLE only):
//   - single requester: grant it.
//   - both requesting: grant !last, unless locked.
//   - locked: req_lock[last] was 1 at last's accepted grant, req_valid[last]=1, and lock_cnt<LOCK_MAX.
//     Then grant last and increment lock_cnt.
//   - lock_cnt resets to 0 when grant changes port or the other port is idle.
//     Lock never blocks once lock_cnt==LOCK_MAX.
//   - last updates to g at each grant.
//  Handshake and edge cases:
//   - req_valid may drop before ack; it is sampled only in IDLE.
//   - Payload change before ack is undefined.
//   - req_ack never asserts to a port with req_valid=0 at the grant edge.
//   - rsp_valid only for reads; at most one bit set; never coincident with mem_en of the same read.
//   - reset during ISSUE/WAIT: pending read dropped, no rsp_valid; next request served normally.
//   - mem_we=0 whenever mem_en=0.
// TESTING
//  1. RD_LAT=2, mem[20'h00010]=64'h0123456789ABCDEF tag 8'h35; port0 read from cycle 0
//     -> mem_en+ack[0] at cycle 1, rsp_valid[0] at cycle 4 with that data/tag.
//  2. Both ports continuous writes from reset, lock=0 -> grant order 0,1,0,1.
//     mem_en every 2nd cycle.
//  3. LOCK_MAX=2, port1 lock=1 streaming writes, port0 waiting -> grant order 1,1,0,1,1,0.
//  4. Port1 writes 64'hFEDC_BA98_7654_3210 tag 8'hA7 at 20'hFFFFF; port0 reads 20'hFFFFF
//     -> rsp_data/rsp_tag equal written values.
//  5. Reset in WAIT cycle of a read -> no rsp_valid, all outputs 0 next cycle.
//     Following port1 read completes normally.
//  6. RD_LAT=1 build -> rsp_valid 2 cycles after mem_en; back-to-back reads ISSUE every 3 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one data+tag memory between two requesters (port 0 = CPU bus
//   adapter, port 1 = I/O channel). Round-robin arbitration with a bounded
//   lock for read-modify-write sequences, and a fixed-latency read path.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   req_valid/we/lock   per-port request, direction and lock-hold flags
//   req_addr/wdata/wtag per-port payloads, port i at [i*W +: W]
//   req_ack             one-cycle accept pulse (coincides with mem_en)
//   rsp_valid           one-cycle read response pulse to the reading port
//   rsp_data/rsp_tag    read data/tag, held until the next response
//   busy                FSM is not in IDLE
//   mem_en/we/addr/...  registered memory command, mem_we qualified by mem_en
//   mem_rdata/rtag      memory read return, valid RD_LAT cycles after mem_en
//
// Handshake: a requester raises req_valid with a stable payload and keeps it
// until it sees req_ack. req_valid is only looked at while the FSM is IDLE,
// so it may be withdrawn before an ack; a port whose req_valid is low at the
// grant edge is never granted. req_ack is a single-cycle pulse.
module mem_arbiter #(
  parameter int AW       = 20,
  parameter int DW       = 64,
  parameter int TW       = 8,
  parameter int RD_LAT   = 2,
  parameter int LOCK_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req_valid,
  input  logic [1:0]      req_we,
  input  logic [1:0]      req_lock,
  input  logic [2*AW-1:0] req_addr,
  input  logic [2*DW-1:0] req_wdata,
  input  logic [2*TW-1:0] req_wtag,
  output logic [1:0]      req_ack,
  output logic [1:0]      rsp_valid,
  output logic [DW-1:0]   rsp_data,
  output logic [TW-1:0]   rsp_tag,
  output logic            busy,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [TW-1:0]   mem_wtag,
  input  logic [DW-1:0]   mem_rdata,
  input  logic [TW-1:0]   mem_rtag
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int LW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state, state_nx;
  logic          port_r;     // port currently being served
  logic          we_r;
  logic          last;       // port of the most recent grant
  logic          lock_flag;  // req_lock of 'last' at its grant
  logic [LW-1:0] lock_cnt;   // consecutive grants to 'last' while the other port waited
  logic [CW-1:0] wait_cnt;

  logic          both;
  logic          lock_hit;
  logic          gnt;
  logic [LW-1:0] cnt_nx;

  // Arbitration. When both ports request, a grant that switches ports already
  // counts as one grant made while the other port waited, so a locking port
  // gets at most LOCK_MAX grants in a row before the waiting port is served.
  always_comb begin
    both     = &req_valid;
    lock_hit = both && lock_flag && (lock_cnt < LW'(LOCK_MAX));
    gnt      = req_valid[1];
    cnt_nx   = '0;
    if (both) begin
      gnt    = lock_hit ? last : ~last;
      cnt_nx = lock_hit ? (lock_cnt + LW'(1)) : LW'(1);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|req_valid) state_nx = ISSUE;
      ISSUE:   state_nx = we_r ? IDLE : WAIT;
      WAIT:    if (wait_cnt == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      port_r    <= 1'b0;
      we_r      <= 1'b0;
      last      <= 1'b1;
      lock_flag <= 1'b0;
      lock_cnt  <= '0;
      wait_cnt  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wtag  <= '0;
      rsp_valid <= 2'b00;
      rsp_data  <= '0;
      rsp_tag   <= '0;
    end else begin
      state     <= state_nx;
      rsp_valid <= 2'b00;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            port_r    <= gnt;
            last      <= gnt;
            lock_flag <= req_lock[gnt];
            lock_cnt  <= cnt_nx;
            we_r      <= req_we[gnt];
            mem_addr  <= gnt ? req_addr[2*AW-1:AW]  : req_addr[AW-1:0];
            mem_wdata <= gnt ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
            mem_wtag  <= gnt ? req_wtag[2*TW-1:TW]  : req_wtag[TW-1:0];
          end
        end
        ISSUE: begin
          if (!we_r) wait_cnt <= CW'(RD_LAT - 1);
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            rsp_valid <= port_r ? 2'b10 : 2'b01;
            rsp_data  <= mem_rdata;
            rsp_tag   <= mem_rtag;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // The memory strobe and the accept pulse are both decoded from ISSUE.
  assign mem_en  = (state == ISSUE);
  assign mem_we  = mem_en & we_r;
  assign req_ack = mem_en ? (port_r ? 2'b10 : 2'b01) : 2'b00;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter. Instance A: RD_LAT=2, LOCK_MAX=2 with a
//   behavioural memory; instance B: RD_LAT=1 with an address-derived memory.
module tb_mem_arbiter;
  localparam int AW = 20;
  localparam int DW = 64;
  localparam int TW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // ---------------- instance A ----------------
  logic [1:0]      a_valid, a_we, a_lock, a_ack, a_rsp_valid;
  logic [2*AW-1:0] a_addr;
  logic [2*DW-1:0] a_wdata;
  logic [2*TW-1:0] a_wtag;
  logic [DW-1:0]   a_rsp_data, a_mem_wdata, a_mem_rdata;
  logic [TW-1:0]   a_rsp_tag, a_mem_wtag, a_mem_rtag;
  logic            a_busy, a_mem_en, a_mem_we;
  logic [AW-1:0]   a_mem_addr;

  mem_arbiter #(.AW(AW), .DW(DW), .TW(TW), .RD_LAT(2), .LOCK_MAX(2)) u_dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_valid), .req_we(a_we), .req_lock(a_lock),
    .req_addr(a_addr), .req_wdata(a_wdata), .req_wtag(a_wtag),
    .req_ack(a_ack), .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_tag(a_rsp_tag),
    .busy(a_busy), .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_wtag(a_mem_wtag),
    .mem_rdata(a_mem_rdata), .mem_rtag(a_mem_rtag)
  );

  // Memory for A: two-stage read pipeline, poison value outside valid slot.
  logic [DW-1:0] a_mem  [logic [AW-1:0]];
  logic [TW-1:0] a_tagm [logic [AW-1:0]];
  logic [DW-1:0] a_p1_d;
  logic [TW-1:0] a_p1_t;
  always @(posedge clk) begin
    if (a_mem_en && a_mem_we) begin
      a_mem[a_mem_addr]  = a_mem_wdata;
      a_tagm[a_mem_addr] = a_mem_wtag;
    end
    if (a_mem_en && !a_mem_we) begin
      a_p1_d <= a_mem.exists(a_mem_addr) ? a_mem[a_mem_addr] : '0;
      a_p1_t <= a_tagm.exists(a_mem_addr) ? a_tagm[a_mem_addr] : '0;
    end else begin
      a_p1_d <= 64'hBAD0_BAD0_BAD0_BAD0;
      a_p1_t <= 8'hEE;
    end
    a_mem_rdata <= a_p1_d;
    a_mem_rtag  <= a_p1_t;
  end

  // ---------------- instance B ----------------
  logic [1:0]      b_valid, b_we, b_lock, b_ack, b_rsp_valid;
  logic [2*AW-1:0] b_addr;
  logic [2*DW-1:0] b_wdata;
  logic [2*TW-1:0] b_wtag;
  logic [DW-1:0]   b_rsp_data, b_mem_wdata, b_mem_rdata;
  logic [TW-1:0]   b_rsp_tag, b_mem_wtag, b_mem_rtag;
  logic            b_busy, b_mem_en, b_mem_we;
  logic [AW-1:0]   b_mem_addr;

  mem_arbiter #(.AW(AW), .DW(DW), .TW(TW), .RD_LAT(1), .LOCK_MAX(4)) u_dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_valid), .req_we(b_we), .req_lock(b_lock),
    .req_addr(b_addr), .req_wdata(b_wdata), .req_wtag(b_wtag),
    .req_ack(b_ack), .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_tag(b_rsp_tag),
    .busy(b_busy), .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_wtag(b_mem_wtag),
    .mem_rdata(b_mem_rdata), .mem_rtag(b_mem_rtag)
  );

  function automatic logic [DW-1:0] b_data(input logic [AW-1:0] ad);
    return {44'h5A5A5, ad};
  endfunction

  always @(posedge clk) begin
    if (b_mem_en && !b_mem_we) begin
      b_mem_rdata <= b_data(b_mem_addr);
      b_mem_rtag  <= b_mem_addr[7:0] ^ 8'h3C;
    end else begin
      b_mem_rdata <= 64'hBAD1_BAD1_BAD1_BAD1;
      b_mem_rtag  <= 8'hEE;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [AW-1:0] wr_addr(input int p, input int k);
    return AW'(32'h200 + p * 16 + k);
  endfunction
  function automatic logic [DW-1:0] wr_data(input int p, input int k);
    return {32'hC0DE_0000 + 32'(p), 32'(k)};
  endfunction
  function automatic logic [TW-1:0] wr_tag(input int p, input int k);
    return TW'(p * 16 + k);
  endfunction

  task automatic set_a(input int p, input logic we, input logic lk, input logic [AW-1:0] ad,
                       input logic [DW-1:0] d, input logic [TW-1:0] t);
    a_we[p] = we;
    a_lock[p] = lk;
    a_addr[p*AW +: AW] = ad;
    a_wdata[p*DW +: DW] = d;
    a_wtag[p*TW +: TW] = t;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    a_valid = 2'b00;
    b_valid = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Streams writes on A and logs grant order, mem_en cycles and write data.
  int gnt_q[$];
  int en_q[$];
  logic [DW-1:0] od_q[$];
  logic [DW-1:0] xd_q[$];

  task automatic stream_writes(input int n, input logic lk1, input logic late1);
    int k[2];
    gnt_q.delete(); en_q.delete(); od_q.delete(); xd_q.delete();
    k[0] = 0;
    k[1] = 0;
    do_reset();
    set_a(0, 1'b1, 1'b0, wr_addr(0, 0), wr_data(0, 0), wr_tag(0, 0));
    set_a(1, 1'b1, lk1, wr_addr(1, 0), wr_data(1, 0), wr_tag(1, 0));
    a_valid = late1 ? 2'b01 : 2'b11;
    for (int c = 1; c <= 4 * n + 8 && gnt_q.size() < n; c++) begin
      @(negedge clk);
      if (a_mem_en) en_q.push_back(c);
      for (int p = 0; p < 2; p++) begin
        if (a_ack[p]) begin
          gnt_q.push_back(p);
          od_q.push_back(a_mem_wdata);
          xd_q.push_back(wr_data(p, k[p]));
          k[p]++;
          set_a(p, 1'b1, (p == 1) ? lk1 : 1'b0, wr_addr(p, k[p]), wr_data(p, k[p]), wr_tag(p, k[p]));
        end
      end
      if (c == 1) a_valid = 2'b11;
    end
    a_valid = 2'b00;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    total++; if (a_ack !== 2'b00) begin bad++; $display("FAIL reset_ack: got %b want 00", a_ack); end
    total++; if (a_rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid: got %b want 00", a_rsp_valid); end
    total++; if ({a_busy, a_mem_en, a_mem_we} !== 3'b000) begin bad++; $display("FAIL reset_busy_en_we: got %b want 000", {a_busy, a_mem_en, a_mem_we}); end
    total++; if ({a_mem_addr, a_mem_wdata, a_mem_wtag} !== '0) begin bad++; $display("FAIL reset_mem_bus: got %h want 0", {a_mem_addr, a_mem_wdata, a_mem_wtag}); end
    total++; if ({a_rsp_data, a_rsp_tag} !== '0) begin bad++; $display("FAIL reset_rsp_data: got %h want 0", {a_rsp_data, a_rsp_tag}); end
    total++; if ({b_busy, b_ack, b_rsp_valid} !== 5'b0) begin bad++; $display("FAIL reset_b: got %b want 0", {b_busy, b_ack, b_rsp_valid}); end
  endtask

  task automatic test_read_latency();
    logic [1:0] exp_rsp;
    do_reset();
    a_mem[20'h00010]  = 64'h0123456789ABCDEF;
    a_tagm[20'h00010] = 8'h35;
    set_a(0, 1'b0, 1'b0, 20'h00010, '0, '0);
    a_valid = 2'b01;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        total++; if ({a_mem_en, a_mem_we, a_ack} !== 4'b1001) begin bad++; $display("FAIL rd_issue: got en/we/ack %b want 1001", {a_mem_en, a_mem_we, a_ack}); end
        total++; if (a_mem_addr !== 20'h00010) begin bad++; $display("FAIL rd_addr: got %h want 00010", a_mem_addr); end
        a_valid = 2'b00;
      end else begin
        total++; if ({a_mem_en, a_ack} !== 3'b000) begin bad++; $display("FAIL rd_quiet_c%0d: got en/ack %b want 000", c, {a_mem_en, a_ack}); end
      end
      exp_rsp = (c == 4) ? 2'b01 : 2'b00;
      total++; if (a_rsp_valid !== exp_rsp) begin bad++; $display("FAIL rd_rsp_valid_c%0d: got %b want %b", c, a_rsp_valid, exp_rsp); end
      if (c >= 4) begin
        total++; if ({a_rsp_data, a_rsp_tag} !== {64'h0123456789ABCDEF, 8'h35}) begin bad++; $display("FAIL rd_data_c%0d: got %h want 0123456789abcdef35", c, {a_rsp_data, a_rsp_tag}); end
      end
    end
  endtask

  task automatic test_rr_writes();
    int exp_g[4] = '{0, 1, 0, 1};
    stream_writes(4, 1'b0, 1'b0);
    total++; if (gnt_q.size() != 4 || en_q.size() != 4) begin bad++; $display("FAIL rr_count: got grants %0d en %0d want 4 4", gnt_q.size(), en_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        total++; if (gnt_q[i] != exp_g[i]) begin bad++; $display("FAIL rr_order_%0d: got %0d want %0d", i, gnt_q[i], exp_g[i]); end
        total++; if (en_q[i] != 2 * i + 1) begin bad++; $display("FAIL rr_en_cycle_%0d: got %0d want %0d", i, en_q[i], 2 * i + 1); end
        total++; if (od_q[i] !== xd_q[i]) begin bad++; $display("FAIL rr_wdata_%0d: got %h want %h", i, od_q[i], xd_q[i]); end
      end
    end
  endtask

  task automatic test_lock();
    int exp_g[7] = '{0, 1, 1, 0, 1, 1, 0};
    stream_writes(7, 1'b1, 1'b1);
    total++; if (gnt_q.size() != 7) begin bad++; $display("FAIL lock_count: got %0d want 7", gnt_q.size()); end
    else begin
      for (int i = 0; i < 7; i++) begin
        total++; if (gnt_q[i] != exp_g[i]) begin bad++; $display("FAIL lock_order_%0d: got %0d want %0d", i, gnt_q[i], exp_g[i]); end
      end
    end
  endtask

  task automatic test_write_read();
    logic got;
    set_a(1, 1'b1, 1'b0, 20'hFFFFF, 64'hFEDC_BA98_7654_3210, 8'hA7);
    a_valid = 2'b10;
    got = 1'b0;
    for (int c = 1; c <= 10 && !got; c++) begin
      @(negedge clk);
      if (a_ack[1]) begin
        got = 1'b1;
        a_valid = 2'b00;
        total++; if ({a_mem_we, a_mem_addr, a_mem_wtag} !== {1'b1, 20'hFFFFF, 8'hA7}) begin bad++; $display("FAIL wr_cmd: got %h want 1fffffa7", {a_mem_we, a_mem_addr, a_mem_wtag}); end
      end
    end
    total++; if (!got) begin bad++; $display("FAIL wr_ack_timeout: got 0 want 1"); end
    set_a(0, 1'b0, 1'b0, 20'hFFFFF, '0, '0);
    a_valid = 2'b01;
    got = 1'b0;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(negedge clk);
      if (a_ack[0]) a_valid = 2'b00;
      if (a_rsp_valid != 2'b00) begin
        got = 1'b1;
        total++; if (a_rsp_valid !== 2'b01) begin bad++; $display("FAIL wr_rd_port: got %b want 01", a_rsp_valid); end
        total++; if ({a_rsp_data, a_rsp_tag} !== {64'hFEDC_BA98_7654_3210, 8'hA7}) begin bad++; $display("FAIL wr_rd_data: got %h want fedcba9876543210a7", {a_rsp_data, a_rsp_tag}); end
      end
    end
    total++; if (!got) begin bad++; $display("FAIL wr_rd_timeout: got 0 want 1"); end
    a_valid = 2'b00;
  endtask

  task automatic test_reset_in_wait();
    logic seen;
    @(negedge clk);
    set_a(0, 1'b0, 1'b0, 20'h00010, '0, '0);
    a_valid = 2'b01;
    @(negedge clk);
    total++; if (a_ack !== 2'b01) begin bad++; $display("FAIL rw_ack: got %b want 01", a_ack); end
    a_valid = 2'b00;
    @(negedge clk);
    total++; if (a_busy !== 1'b1 || a_mem_en !== 1'b0) begin bad++; $display("FAIL rw_wait_state: got busy/en %b want 10", {a_busy, a_mem_en}); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if ({a_ack, a_rsp_valid, a_busy, a_mem_en, a_mem_we} !== 7'b0) begin bad++; $display("FAIL rw_ctrl_zero: got %b want 0", {a_ack, a_rsp_valid, a_busy, a_mem_en, a_mem_we}); end
    total++; if ({a_mem_addr, a_mem_wdata, a_mem_wtag, a_rsp_data, a_rsp_tag} !== '0) begin bad++; $display("FAIL rw_data_zero: got %h want 0", {a_mem_addr, a_rsp_data, a_rsp_tag}); end
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (a_rsp_valid != 2'b00) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL rw_dropped: got rsp 1 want 0"); end
    set_a(1, 1'b0, 1'b0, 20'hFFFFF, '0, '0);
    a_valid = 2'b10;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        total++; if (a_ack !== 2'b10) begin bad++; $display("FAIL rw_p1_ack: got %b want 10", a_ack); end
        a_valid = 2'b00;
      end
      if (c == 4) begin
        total++; if (a_rsp_valid !== 2'b10) begin bad++; $display("FAIL rw_p1_rsp: got %b want 10", a_rsp_valid); end
        total++; if ({a_rsp_data, a_rsp_tag} !== {64'hFEDC_BA98_7654_3210, 8'hA7}) begin bad++; $display("FAIL rw_p1_data: got %h want fedcba9876543210a7", {a_rsp_data, a_rsp_tag}); end
      end
    end
  endtask

  task automatic test_rdlat1_back_to_back();
    int en_c[$];
    int rsp_c[$];
    logic [DW+TW-1:0] rd_q[$];
    logic [DW+TW-1:0] exp_q[$];
    int k;
    do_reset();
    k = 0;
    b_we = 2'b00;
    b_lock = 2'b00;
    b_addr = '0;
    b_addr[AW-1:0] = 20'h00300;
    b_valid = 2'b01;
    for (int c = 1; c <= 15 && rsp_c.size() < 3; c++) begin
      @(negedge clk);
      if (b_mem_en) begin
        en_c.push_back(c);
        exp_q.push_back({b_data(20'h00300 + 20'(k)), 8'(8'h00 + k) ^ 8'h3C});
      end
      if (b_ack[0]) begin
        k++;
        b_addr[AW-1:0] = 20'h00300 + 20'(k);
      end
      if (b_rsp_valid != 2'b00) begin
        rsp_c.push_back(c);
        rd_q.push_back({b_rsp_data, b_rsp_tag});
      end
      if (rsp_c.size() == 3) b_valid = 2'b00;
    end
    b_valid = 2'b00;
    total++; if (en_c.size() < 3 || rsp_c.size() != 3) begin bad++; $display("FAIL l1_count: got en %0d rsp %0d want 3 3", en_c.size(), rsp_c.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        total++; if (en_c[i] != 3 * i + 1) begin bad++; $display("FAIL l1_en_cycle_%0d: got %0d want %0d", i, en_c[i], 3 * i + 1); end
        total++; if (rsp_c[i] != 3 * i + 3) begin bad++; $display("FAIL l1_rsp_cycle_%0d: got %0d want %0d", i, rsp_c[i], 3 * i + 3); end
        total++; if (rd_q[i] !== exp_q[i]) begin bad++; $display("FAIL l1_data_%0d: got %h want %h", i, rd_q[i], exp_q[i]); end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    a_valid = '0; a_we = '0; a_lock = '0; a_addr = '0; a_wdata = '0; a_wtag = '0;
    b_valid = '0; b_we = '0; b_lock = '0; b_addr = '0; b_wdata = '0; b_wtag = '0;
    test_reset();
    test_read_latency();
    test_rr_writes();
    test_lock();
    test_write_read();
    test_reset_in_wait();
    test_rdlat1_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
